// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Purpose  : Debounced button front-end that assembles a 16-bit instruction
//            from two byte presses; a third press issues the execute pulse.
//            Optional odd-parity byte checking when INST_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module inst_loader #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [7:0] data_in,
`ifdef INST_PARITY_EN
    input  logic       data_par,
`endif
    output logic [3:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic [7:0] imm,
    output logic       inst_done,
    output logic       btn_edge,
    output logic       byte_stb,
    output logic       load_phase,
    output logic       parity_err
);

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD_HI = 2'd0,
        ST_LOAD_LO = 2'd1,
        ST_READY   = 2'd2,
        ST_EXEC    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_db_level;
    logic [CNT_W-1:0] r_db_cnt;
    logic [7:0]       r_data_q;
    logic [3:0]       r_opcode;
    logic [1:0]       r_rd;
    logic [1:0]       r_rs;
    logic [7:0]       r_imm;
    logic             r_inst_done;
    logic             r_btn_edge;
    logic             r_byte_stb;
    logic             r_load_phase;
    logic             w_accept;
    logic             w_press;
    logic             w_par_ok;
    logic             w_ld_hi;
    logic             w_ld_lo;
    logic             w_exec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_data_q <= 8'h00;
        end else begin
            r_s1     <= btn;
            r_s2     <= r_s1;
            r_data_q <= data_in;
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive differing samples.
    assign w_accept = (r_s2 != r_db_level) && (r_db_cnt == c_DB_LAST);
    assign w_press  = w_accept && r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (r_s2 == r_db_level) begin
            r_db_cnt   <= '0;
        end else if (w_accept) begin
            r_db_level <= r_s2;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + CNT_W'(1);
        end
    end

`ifdef INST_PARITY_EN
    logic r_par_q;
    logic r_parity_err;
    logic w_par_rej;

    always_ff @(posedge clk) begin
        if (rst) r_par_q <= 1'b0;
        else     r_par_q <= data_par;
    end

    assign w_par_ok  = ^{r_par_q, r_data_q};
    assign w_par_rej = w_press && !w_par_ok &&
                       ((r_state == ST_LOAD_HI) || (r_state == ST_LOAD_LO));

    always_ff @(posedge clk) begin
        if (rst)                    r_parity_err <= 1'b0;
        else if (w_par_rej)         r_parity_err <= 1'b1;
        else if (w_ld_hi | w_ld_lo) r_parity_err <= 1'b0;
    end

    assign parity_err = r_parity_err;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_LOAD_HI;
        else     r_state <= w_state_nxt;
    end

    // The execute pulse is issued while still in READY; EXEC follows it so that
    // inst_done covers both the pulse cycle and the one after.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_hi     = 1'b0;
        w_ld_lo     = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            ST_LOAD_HI: begin
                if (w_press && w_par_ok) begin
                    w_ld_hi     = 1'b1;
                    w_state_nxt = ST_LOAD_LO;
                end
            end
            ST_LOAD_LO: begin
                if (w_press && w_par_ok) begin
                    w_ld_lo     = 1'b1;
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (r_btn_edge)   w_state_nxt = ST_EXEC;
                else if (w_press) w_exec      = 1'b1;
            end
            ST_EXEC:  w_state_nxt = ST_LOAD_HI;
            default:  w_state_nxt = ST_LOAD_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode     <= 4'h0;
            r_rd         <= 2'd0;
            r_rs         <= 2'd0;
            r_imm        <= 8'h00;
            r_inst_done  <= 1'b0;
            r_btn_edge   <= 1'b0;
            r_byte_stb   <= 1'b0;
            r_load_phase <= 1'b0;
        end else begin
            r_byte_stb  <= w_ld_hi | w_ld_lo;
            r_btn_edge  <= w_exec;
            r_inst_done <= (w_state_nxt == ST_READY) || (w_state_nxt == ST_EXEC);
            if (w_ld_hi) begin
                r_opcode     <= r_data_q[7:4];
                r_rd         <= r_data_q[3:2];
                r_rs         <= r_data_q[1:0];
                r_load_phase <= 1'b1;
            end
            if (w_ld_lo) begin
                r_imm        <= r_data_q;
                r_load_phase <= 1'b0;
            end
        end
    end

    assign opcode     = r_opcode;
    assign rd         = r_rd;
    assign rs         = r_rs;
    assign imm        = r_imm;
    assign inst_done  = r_inst_done;
    assign btn_edge   = r_btn_edge;
    assign byte_stb   = r_byte_stb;
    assign load_phase = r_load_phase;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// Testbench for inst_loader: randomized button/byte traffic against an
// instruction-level reference model, with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_inst_loader;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] data_in = 8'h00;
`ifdef INST_PARITY_EN
    logic       data_par = 1'b1;
    bit         par_flip = 1'b0;
    bit         m_perr   = 1'b0;
`endif
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       inst_done;
    logic       btn_edge;
    logic       byte_stb;
    logic       load_phase;
    logic       parity_err;

    inst_loader #(.DB_CYCLES(DB), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .data_in    (data_in),
`ifdef INST_PARITY_EN
        .data_par   (data_par),
`endif
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .imm        (imm),
        .inst_done  (inst_done),
        .btn_edge   (btn_edge),
        .byte_stb   (byte_stb),
        .load_phase (load_phase),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_edge;
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic       lp;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: which byte the next press fills, and the instruction held.
    int         m_phase = 0;
    logic [3:0] m_op  = 4'h0;
    logic [1:0] m_rd  = 2'd0;
    logic [1:0] m_rs  = 2'd0;
    logic [7:0] m_imm = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_op = 4'h0; m_rd = 2'd0; m_rs = 2'd0; m_imm = 8'h00;
`ifdef INST_PARITY_EN
        m_perr = 1'b0;
`endif
    endfunction

    // A press is a high run of at least DB edges; its effect shows DB+2 edges after the first.
    function automatic void model_press(input int start, input logic [7:0] d);
        exp_t e;
`ifdef INST_PARITY_EN
        if (m_phase != 2) begin
            if ((^{data_par, d}) == 1'b0) begin
                m_perr = 1'b1;
                return;
            end
            m_perr = 1'b0;
        end
`endif
        e.cyc = start + DB + 2;
        e.is_edge = 1'b0;
        case (m_phase)
            0: begin
                m_op = d[7:4]; m_rd = d[3:2]; m_rs = d[1:0];
                e.lp = 1'b1; e.done = 1'b0; m_phase = 1;
            end
            1: begin
                m_imm = d;
                e.lp = 1'b0; e.done = 1'b1; m_phase = 2;
            end
            default: begin
                e.is_edge = 1'b1;
                e.lp = 1'b0; e.done = 1'b1; m_phase = 0;
            end
        endcase
        e.op = m_op; e.rd = m_rd; e.rs = m_rs; e.imm = m_imm;
        sb.push_back(e);
    endfunction

    task automatic run_btn(input int hi, input int lo, input logic [7:0] d);
        int start;
        @(negedge clk);
        data_in = d;
`ifdef INST_PARITY_EN
        data_par = (~^d) ^ par_flip;
`endif
        @(negedge clk);
        btn = 1'b1;
        start = cyc;
        if (hi >= DB) model_press(start, d);
        repeat (hi) @(negedge clk);
        btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every strobe/pulse must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (byte_stb || btn_edge)) begin
                if (byte_stb && btn_edge) check("stb_and_edge", 1, 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got byte_stb=%0b btn_edge=%0b expected none (cycle %0d)",
                             byte_stb, btn_edge, cyc);
                end else begin
                    e = sb.pop_front();
                    check("kind_is_edge", btn_edge, e.is_edge);
                    check("latency_cycle", cyc, e.cyc);
                    check("opcode", opcode, e.op);
                    check("rd", rd, e.rd);
                    check("rs", rs, e.rs);
                    check("imm", imm, e.imm);
                    check("load_phase", load_phase, e.lp);
                    check("inst_done", inst_done, e.done);
                    if (btn_edge) begin
                        @(negedge clk);
                        check("edge_width", btn_edge, 0);
                        check("done_in_exec", inst_done, 1);
                        @(negedge clk);
                        check("done_cleared", inst_done, 0);
                        check("fields_kept_op", opcode, e.op);
                        check("fields_kept_imm", imm, e.imm);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset held with button pressed and all switches on.
        rst = 1'b1;
        btn = 1'b1;
        data_in = 8'hFF;
`ifdef INST_PARITY_EN
        data_par = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("rst_opcode", opcode, 0);
        check("rst_rd_rs", {rd, rs}, 0);
        check("rst_imm", imm, 0);
        check("rst_flags", {inst_done, btn_edge, byte_stb, load_phase, parity_err}, 0);
        rst = 1'b0;
        model_reset();
        model_press(cyc, data_in);
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        drain();

        // Full load and execute.
        do_reset();
        run_btn(8, 10, 8'h5A);
        run_btn(8, 10, 8'h3C);
        run_btn(8, 10, 8'h00);
        drain();
        check("exec_fields", {opcode, rd, rs, imm}, {m_op, m_rd, m_rs, m_imm});
        check("exec_fields_abs", {opcode, rd, rs, imm}, 16'h5A3C);

        // Short glitches never accepted, then exact-minimum press.
        for (int i = 0; i < 5; i++) run_btn(DB - 1, 8, 8'hC3);
        run_btn(DB, 10, 8'h96);
        drain();

        // Long hold yields a single press.
        run_btn(100, 10, 8'h4E);
        drain();
        check("hold_phase", load_phase, m_phase == 1);

        // Reset in the middle of a load.
        do_reset();
        run_btn(8, 10, 8'hA1);
        drain();
        check("hi_loaded", opcode, 4'hA);
        check("hi_phase", load_phase, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_opcode", opcode, 0);
        check("midrst_phase", load_phase, 0);
        rst = 1'b0;
        model_reset();
        run_btn(8, 10, 8'h77);
        drain();

        // Randomized mix of glitches and presses.
        for (int i = 0; i < 40; i++) begin
            int hi;
            if ($urandom_range(0, 3) == 0) hi = $urandom_range(1, DB - 1);
            else                           hi = $urandom_range(DB, DB + 12);
            run_btn(hi, $urandom_range(8, 14), 8'($urandom));
        end
        drain();
        check("idle_done", inst_done, (m_phase == 2) ? 1 : 0);
        check("idle_phase", load_phase, (m_phase == 1) ? 1 : 0);

`ifdef INST_PARITY_EN
        do_reset();
        par_flip = 1'b1;
        run_btn(8, 10, 8'h01);
        check("par_reject_err", parity_err, 1);
        check("par_reject_phase", load_phase, 0);
        par_flip = 1'b0;
        run_btn(8, 10, 8'h01);
        drain();
        check("par_accept_op", opcode, 0);
        check("par_accept_phase", load_phase, 1);
        check("par_err_model", parity_err, m_perr);
`endif
        check("parity_err_final", parity_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
